// File: rtl/ps2_scancode_receiver_pkg.sv
// Shared constants and frame-FSM state encoding for the PS/2 scancode receiver.
package ps2_scancode_receiver_pkg;

   localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
   localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } frame_state_t;

   // Odd parity: data plus parity bit must hold an odd number of ones.
   function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/ps2_scancode_receiver_line_filter.sv
// Synchronizer, glitch filter and falling-edge detector for the raw PS/2 clock line.
module ps2_line_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic line,
   output logic fall
);

   localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

   logic          meta;
   logic          sync;
   logic          level;
   logic [CW-1:0] cnt;

   // Idle-high reset so a keyboard at rest never looks like a start edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta  <= 1'b1;
         sync  <= 1'b1;
         level <= 1'b1;
         cnt   <= '0;
         fall  <= 1'b0;
      end else begin
         meta <= line;
         sync <= meta;
         fall <= 1'b0;
         if (sync != level) begin
            if (cnt == CW'(FILTER_LEN - 1)) begin
               level <= sync;
               cnt   <= '0;
               fall  <= level;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/ps2_scancode_receiver.sv
// PS/2 keyboard frame receiver that decodes E0/F0 prefixes into make/break events.
module ps2_scancode_receiver
   import ps2_scancode_receiver_pkg::*;
#(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ps2_clk,
   input  logic         ps2_data,
   output logic [7:0]   scancode,
   output logic         push_down,
   output logic         push_up,
   output logic         extended,
   output logic         frame_err,
   output frame_state_t dbg_state
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   frame_state_t  state_q, state_d;
   logic          fall;
   logic          data_meta, data_s;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift_q;
   logic          parity_q;
   logic [TW-1:0] to_cnt;
   logic          pend_ext, pend_brk;

   logic          timeout_hit;
   logic          byte_ok;
   logic          frame_err_d;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
      .clk   (clk),
      .rst_n (rst_n),
      .line  (ps2_clk),
      .fall  (fall)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_meta <= 1'b1;
         data_s    <= 1'b1;
      end else begin
         data_meta <= ps2_data;
         data_s    <= data_meta;
      end
   end

   // Frame FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Frame FSM: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:   if (fall && !data_s) state_d = ST_DATA;
         ST_DATA:   if (timeout_hit) state_d = ST_IDLE;
                    else if (fall && bit_cnt == 3'd7) state_d = ST_PARITY;
         ST_PARITY: if (timeout_hit) state_d = ST_IDLE;
                    else if (fall) state_d = ST_STOP;
         ST_STOP:   if (timeout_hit || fall) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Frame FSM: outputs. The timeout never fires on a cycle that carries an edge.
   always_comb begin
      timeout_hit = 1'b0;
      byte_ok     = 1'b0;
      frame_err_d = 1'b0;
      if (state_q != ST_IDLE && !fall && to_cnt == TW'(TIMEOUT_CYC - 1))
         timeout_hit = 1'b1;
      if (state_q == ST_STOP && fall) begin
         if (data_s && odd_parity_ok(shift_q, parity_q)) byte_ok = 1'b1;
         else                                              frame_err_d = 1'b1;
      end
      if (timeout_hit) frame_err_d = 1'b1;
   end

   assign dbg_state = state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt  <= '0;
         shift_q  <= '0;
         parity_q <= 1'b0;
         to_cnt   <= '0;
      end else begin
         if (state_q == ST_IDLE || fall || timeout_hit) to_cnt <= '0;
         else                                          to_cnt <= to_cnt + 1'b1;
         if (fall) begin
            unique case (state_q)
               ST_IDLE:   bit_cnt <= '0;
               ST_DATA: begin
                  shift_q <= {data_s, shift_q[7:1]};
                  bit_cnt <= bit_cnt + 1'b1;
               end
               ST_PARITY: parity_q <= data_s;
               default: ;
            endcase
         end
      end
   end

   // Prefix tracking and event generation; pulses land one cycle after the stop bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scancode  <= '0;
         extended  <= 1'b0;
         push_down <= 1'b0;
         push_up   <= 1'b0;
         frame_err <= 1'b0;
         pend_ext  <= 1'b0;
         pend_brk  <= 1'b0;
      end else begin
         push_down <= 1'b0;
         push_up   <= 1'b0;
         frame_err <= frame_err_d;
         if (frame_err_d) begin
            pend_ext <= 1'b0;
            pend_brk <= 1'b0;
         end else if (byte_ok) begin
            if (shift_q == PS2_PREFIX_EXT) begin
               pend_ext <= 1'b1;
            end else if (shift_q == PS2_PREFIX_BRK) begin
               pend_brk <= 1'b1;
            end else begin
               scancode  <= shift_q;
               extended  <= pend_ext;
               push_up   <= pend_brk;
               push_down <= !pend_brk;
               pend_ext  <= 1'b0;
               pend_brk  <= 1'b0;
            end
         end
      end
   end

endmodule

// File: doc/ps2_scancode_receiver.md
PS2_SCANCODE_RECEIVER -- requirements
Module: ps2_scancode_receiver

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: number of consecutive clk samples ps2_clk must hold a level before it is accepted.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 100000: number of clk cycles without an accepted ps2_clk falling edge that aborts a frame in progress (1 ms at 100 MHz).
REQ-003 SHALL have port clk, input, 1 bit: system clock; the sole clock of the block.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port ps2_clk, input, 1 bit: raw PS/2 clock from the keyboard, asynchronous to clk.
REQ-006 SHALL have port ps2_data, input, 1 bit: raw PS/2 data from the keyboard, asynchronous to clk.
REQ-007 SHALL have port scancode, output, 8 bits: last make/break code; holds its value until the next event.
REQ-008 SHALL have port push_down, output, 1 bit: one-cycle pulse; key pressed (make code), valid with scancode.
REQ-009 SHALL have port push_up, output, 1 bit: one-cycle pulse; key released (break code), valid with scancode.
REQ-010 SHALL have port extended, output, 1 bit: set when the current event was prefixed by E0; held with scancode.
REQ-011 SHALL have port frame_err, output, 1 bit: one-cycle pulse on parity error, stop-bit error or timeout.

Function
REQ-012 SHALL pass ps2_clk and ps2_data each through a 2-flop synchronizer before any use.
REQ-013 SHALL change the filtered ps2_clk level only after FILTER_LEN identical consecutive synchronized samples.
REQ-014 SHALL sample synchronized ps2_data on the cycle a filtered ps2_clk falling edge is detected.
REQ-015 SHALL run a frame FSM with states IDLE, DATA, PARITY and STOP.
REQ-016 IDLE: on a falling edge with data=0 (start bit), SHALL go to DATA and clear the bit counter; with data=1, SHALL stay in IDLE and report no error.
REQ-017 DATA: SHALL shift in 8 bits LSB first, one per falling edge, and go to PARITY after the 8th.
REQ-018 PARITY: SHALL latch the bit and go to STOP; the parity check is odd (8 data bits plus parity SHALL contain an odd number of ones).
REQ-019 STOP: SHALL require data=1 and good parity to accept the byte; on either failure SHALL pulse frame_err and discard the byte; SHALL return to IDLE in both cases.
REQ-020 SHALL, in any state other than IDLE, pulse frame_err, discard the partial byte and return to IDLE once TIMEOUT_CYC cycles pass with no accepted falling edge.
REQ-021 An accepted byte of 0xE0 SHALL set the pending extended flag and produce no pulse.
REQ-022 An accepted byte of 0xF0 SHALL set the pending break flag and produce no pulse.
REQ-023 Any other accepted byte SHALL load scancode and load extended from the pending flag.
REQ-024 That byte SHALL pulse push_up if the break flag is pending, otherwise push_down.
REQ-025 That byte SHALL clear both pending flags.
REQ-026 The event pulse SHALL occur exactly 1 clk after the cycle the stop bit is sampled; push_down and push_up SHALL never be high together.
REQ-027 Typematic repeats (the same make code received again) SHALL each produce a push_down pulse; no deduplication.
REQ-028 Any frame_err event SHALL clear both pending flags; scancode and extended SHALL keep their values.
REQ-029 A second F0 or E0 received while that flag is already pending SHALL leave the flag set, with no error.

Reset
REQ-030 While rst_n=0: FSM=IDLE, scancode=0x00, push_down=0, push_up=0, extended=0, frame_err=0, pending flags=0, bit counter=0, timeout counter=0.
REQ-031 While rst_n=0: synchronizer flops and filter level SHALL be 1 (PS/2 idle-high).
REQ-032 Reset asserted mid-frame SHALL abort the frame with no pulse, including no frame_err.

Structure
REQ-033 A shared package SHALL hold the constants PS2_PREFIX_EXT=0xE0 and PS2_PREFIX_BRK=0xF0 and the frame-FSM state enumeration.
REQ-034 The synchronizer plus FILTER_LEN filter plus falling-edge detector SHALL be one sub-module, ps2_line_filter, instantiated once for ps2_clk; ps2_data uses the synchronizer only.

Verification
REQ-035 Frame 0x1C with odd parity 0 and stop 1 -> one push_down pulse, scancode=0x1C, extended=0, push_up stays 0.
REQ-036 Frames F0 then 0x12 -> exactly one push_up pulse, scancode=0x12, no pulse after F0 alone.
REQ-037 Frames E0, F0, 0x74 -> push_up pulse, scancode=0x74, extended=1; a following 0x1C -> push_down pulse with extended=0.
REQ-038 Frame 0x58 with wrong parity -> frame_err pulse, no push pulse, scancode unchanged; a following good frame 0x58 -> push_down pulse.
REQ-039 Start bit plus 4 data bits then ps2_clk held high for TIMEOUT_CYC+10 cycles -> one frame_err pulse, FSM=IDLE; next good frame 0x0E -> push_down pulse.
REQ-040 Glitches on ps2_clk shorter than FILTER_LEN-1 cycles during a 0x1C frame -> no extra bits shifted, push_down pulse with scancode=0x1C; rst_n low mid-frame -> all outputs 0, no pulses.
